// File: rtl/dispatch_ctrl.sv
// Dispatch scheduler between the decoder and the out-of-order back end.
// Holds one decoded instruction, tracks ROB/RS/LSB free capacity with credit
// counters, hands out ROB tags in order and steers each instruction to the
// reservation station or the load/store buffer.
module dispatch_ctrl #(
    parameter int ROB_DEPTH = 16,
    parameter int RS_DEPTH  = 16,
    parameter int LSB_DEPTH = 16,
    parameter int OP_W      = 6,
    parameter int TAG_W     = $clog2(ROB_DEPTH),
    parameter int LSB_KW    = $clog2(LSB_DEPTH) + 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              id_en,
    input  logic [1:0]        id_cls,
    input  logic [OP_W-1:0]   id_op,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_imm,
    input  logic [31:0]       id_pc,
    output logic              id_ready,
    input  logic              rob_commit,
    input  logic [TAG_W-1:0]  rob_head,
    input  logic              rs_free,
    input  logic              lsb_free,
    input  logic [LSB_KW-1:0] lsb_kept,
    output logic              rs_en,
    output logic              lsb_en,
    output logic [OP_W-1:0]   iss_op,
    output logic [4:0]        iss_rs1,
    output logic [4:0]        iss_rs2,
    output logic [4:0]        iss_rd,
    output logic [31:0]       iss_imm,
    output logic [31:0]       iss_pc,
    output logic [TAG_W-1:0]  iss_tag,
    output logic              rob_en,
    output logic              ren_en,
    output logic [4:0]        ren_rd
);

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_HOLD   = 1'b1;

    localparam logic [1:0] CLS_LOAD  = 2'b01;
    localparam logic [1:0] CLS_STORE = 2'b10;

    // Credit counters share one width wide enough to hold the largest depth.
    localparam int ROB_CW = $clog2(ROB_DEPTH) + 1;
    localparam int RS_CW  = $clog2(RS_DEPTH) + 1;
    localparam int LSB_CW = $clog2(LSB_DEPTH) + 1;
    localparam int CR_W   = (ROB_CW > RS_CW) ? ((ROB_CW > LSB_CW) ? ROB_CW : LSB_CW)
                                             : ((RS_CW > LSB_CW) ? RS_CW : LSB_CW);

    // Index 0 = ROB, 1 = RS, 2 = LSB.
    localparam logic [2:0][CR_W-1:0] DEPTHS = {CR_W'(LSB_DEPTH), CR_W'(RS_DEPTH), CR_W'(ROB_DEPTH)};
    localparam logic [CR_W-1:0]  CR_ONE   = CR_W'(1);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(ROB_DEPTH - 1);

    logic [0:0]      state_reg;
    logic [0:0]      state_next;
    logic [1:0]      cls_reg;
    logic [OP_W-1:0] op_reg;
    logic [4:0]      rs1_reg;
    logic [4:0]      rs2_reg;
    logic [4:0]      rd_reg;
    logic [31:0]     imm_reg;
    logic [31:0]     pc_reg;
    logic [TAG_W-1:0] tag_reg;

    logic            is_mem;
    logic            can_dispatch;
    logic            dispatch;
    logic            capture;
    logic [2:0]      take;
    logic [2:0]      give;
    logic [2:0]      avail;
    logic [CR_W-1:0] lsb_kept_w;
    logic [CR_W-1:0] lsb_clr;

    assign is_mem = (cls_reg == CLS_LOAD) || (cls_reg == CLS_STORE);

    // A release arriving in the same cycle counts as available capacity, so a
    // counter sitting at zero can still dispatch against the incoming free.
    assign can_dispatch = (state_reg == ST_HOLD) && avail[0] && (is_mem ? avail[2] : avail[1]);
    assign id_ready     = (state_reg == ST_EMPTY) || can_dispatch;
    assign dispatch     = can_dispatch && rdy_in && !clear;
    assign capture      = id_en && id_ready && rdy_in && !clear;

    assign take = {dispatch && is_mem, dispatch && !is_mem, dispatch};
    assign give = {lsb_free, rs_free, rob_commit};

    // Stores already committed stay resident in the LSB across a flush.
    assign lsb_kept_w = CR_W'(lsb_kept);
    assign lsb_clr    = (lsb_kept_w >= DEPTHS[2]) ? '0 : DEPTHS[2] - lsb_kept_w;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_credit
            logic [CR_W-1:0] cr_reg;
            logic [CR_W-1:0] cr_next;
            logic [CR_W-1:0] clr_val;

            assign clr_val   = (gi == 2) ? lsb_clr : DEPTHS[gi];
            assign avail[gi] = (cr_reg != '0) || give[gi];

            // Next credit: consume on dispatch, return on free, saturate at depth.
            always_comb begin
                cr_next = cr_reg;
                if (clear) begin
                    cr_next = clr_val;
                end else if (take[gi] && !give[gi]) begin
                    cr_next = cr_reg - CR_ONE;
                end else if (give[gi] && !take[gi] && (cr_reg != DEPTHS[gi])) begin
                    cr_next = cr_reg + CR_ONE;
                end
            end

            // Credit register, frozen while the core is stalled.
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    cr_reg <= DEPTHS[gi];
                end else if (rdy_in) begin
                    cr_reg <= cr_next;
                end
            end
        end
    endgenerate

    // Buffer state: a new capture keeps us in HOLD even while the old entry leaves.
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_EMPTY;
        end else if (capture) begin
            state_next = ST_HOLD;
        end else if (dispatch) begin
            state_next = ST_EMPTY;
        end
    end

    // Single-entry instruction buffer and its state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= ST_EMPTY;
            cls_reg   <= '0;
            op_reg    <= '0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            rd_reg    <= '0;
            imm_reg   <= '0;
            pc_reg    <= '0;
        end else if (rdy_in) begin
            state_reg <= state_next;
            if (capture) begin
                cls_reg <= id_cls;
                op_reg  <= id_op;
                rs1_reg <= id_rs1;
                rs2_reg <= id_rs2;
                rd_reg  <= id_rd;
                imm_reg <= id_imm;
                pc_reg  <= id_pc;
            end
        end
    end

    // ROB tag allocator: in-order, wraps at ROB_DEPTH, realigns to head on flush.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tag_reg <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                tag_reg <= rob_head;
            end else if (dispatch) begin
                tag_reg <= (tag_reg == TAG_LAST) ? '0 : tag_reg + TAG_ONE;
            end
        end
    end

    // Registered issue port: strobes pulse for one cycle per dispatch, data holds.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rob_en  <= 1'b0;
            rs_en   <= 1'b0;
            lsb_en  <= 1'b0;
            ren_en  <= 1'b0;
            ren_rd  <= '0;
            iss_op  <= '0;
            iss_rs1 <= '0;
            iss_rs2 <= '0;
            iss_rd  <= '0;
            iss_imm <= '0;
            iss_pc  <= '0;
            iss_tag <= '0;
        end else begin
            rob_en <= dispatch;
            rs_en  <= dispatch && !is_mem;
            lsb_en <= dispatch && is_mem;
            ren_en <= dispatch && (cls_reg != CLS_STORE) && (rd_reg != 5'd0);
            if (dispatch) begin
                ren_rd  <= rd_reg;
                iss_op  <= op_reg;
                iss_rs1 <= rs1_reg;
                iss_rs2 <= rs2_reg;
                iss_rd  <= rd_reg;
                iss_imm <= imm_reg;
                iss_pc  <= pc_reg;
                iss_tag <= tag_reg;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Testbench for dispatch_ctrl: scoreboard of captured instructions checked
// against every issue strobe, plus directed timing/credit checks.
module tb_dispatch_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        id_en;
    logic [1:0]  id_cls;
    logic [5:0]  id_op;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        rob_commit;
    logic [3:0]  rob_head;
    logic        rs_free;
    logic        lsb_free;
    logic [4:0]  lsb_kept;
    logic        rs_en;
    logic        lsb_en;
    logic [5:0]  iss_op;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic [31:0] iss_imm;
    logic [31:0] iss_pc;
    logic [3:0]  iss_tag;
    logic        rob_en;
    logic        ren_en;
    logic [4:0]  ren_rd;

    typedef struct packed {
        logic [1:0]  cls;
        logic [5:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
    } ins_t;

    ins_t exp_q[$];
    int   exp_tag   = 0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   lsb_cnt   = 0;
    int   first_cyc = 0;
    int   last_cyc  = 0;
    ins_t mon_e;
    bit   mon_mem;
    bit   mon_ren;

    dispatch_ctrl #(
        .ROB_DEPTH(16),
        .RS_DEPTH (16),
        .LSB_DEPTH(16),
        .OP_W     (6)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .clear     (clear),
        .id_en     (id_en),
        .id_cls    (id_cls),
        .id_op     (id_op),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .id_imm    (id_imm),
        .id_pc     (id_pc),
        .id_ready  (id_ready),
        .rob_commit(rob_commit),
        .rob_head  (rob_head),
        .rs_free   (rs_free),
        .lsb_free  (lsb_free),
        .lsb_kept  (lsb_kept),
        .rs_en     (rs_en),
        .lsb_en    (lsb_en),
        .iss_op    (iss_op),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_imm   (iss_imm),
        .iss_pc    (iss_pc),
        .iss_tag   (iss_tag),
        .rob_en    (rob_en),
        .ren_en    (ren_en),
        .ren_rd    (ren_rd)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Present one instruction for a cycle; push it to the scoreboard if handshaken.
    task automatic present(input logic [1:0] cls, input logic [5:0] op, input logic [4:0] rd,
                           input logic [31:0] pc, output bit taken);
        ins_t e;
        id_en  = 1'b1;
        id_cls = cls;
        id_op  = op;
        id_rs1 = pc[6:2];
        id_rs2 = pc[11:7];
        id_rd  = rd;
        id_imm = ~pc;
        id_pc  = pc;
        #1;
        taken = id_ready && rdy_in && !clear;
        if (taken) begin
            e.cls = cls;
            e.op  = op;
            e.rs1 = pc[6:2];
            e.rs2 = pc[11:7];
            e.rd  = rd;
            e.imm = ~pc;
            e.pc  = pc;
            exp_q.push_back(e);
        end
        @(posedge clk_in);
        #1;
        id_en = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        rst_in     = 1'b0;
        id_en      = 1'b0;
        clear      = 1'b0;
        rob_commit = 1'b0;
        rs_free    = 1'b0;
        lsb_free   = 1'b0;
        rdy_in     = 1'b1;
        tick();
        tick();
        exp_q.delete();
        exp_tag = 0;
        rst_in  = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: every issue strobe must match the oldest captured entry.
    always @(negedge clk_in) begin
        cyc++;
        if (rst_in) begin
            if (rs_en || lsb_en) begin
                chk("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e   = exp_q.pop_front();
                    mon_mem = (mon_e.cls == 2'b01) || (mon_e.cls == 2'b10);
                    mon_ren = (mon_e.cls != 2'b10) && (mon_e.rd != 5'd0);
                    chk("path", 64'({rs_en, lsb_en}), 64'(mon_mem ? 2'b01 : 2'b10));
                    chk("rob_en", 64'(rob_en), 64'd1);
                    chk("tag", 64'(iss_tag), 64'(exp_tag));
                    chk("fields", 64'({iss_op, iss_rs1, iss_rs2, iss_rd, iss_imm}),
                        64'({mon_e.op, mon_e.rs1, mon_e.rs2, mon_e.rd, mon_e.imm}));
                    chk("pc", 64'(iss_pc), 64'(mon_e.pc));
                    chk("ren_en", 64'(ren_en), 64'(mon_ren));
                    if (mon_ren) chk("ren_rd", 64'(ren_rd), 64'(mon_e.rd));
                    $display("issue tag=%0d cls=%0d pc=%08h ren=%0b rd=%0d",
                             iss_tag, mon_e.cls, iss_pc, ren_en, iss_rd);
                    exp_tag = (exp_tag + 1) % 16;
                end
                if (lsb_en) begin
                    lsb_cnt++;
                    if (lsb_cnt == 1) first_cyc = cyc;
                    last_cyc = cyc;
                end
            end else begin
                chk("rob_idle", 64'(rob_en), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit t;
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; id_en = 1'b0;
        id_cls = '0; id_op = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_imm = '0; id_pc = '0; rob_commit = 1'b0; rob_head = '0;
        rs_free = 1'b0; lsb_free = 1'b0; lsb_kept = '0;
        tick();
        tick();
        chk("rst_rob_en", 64'(rob_en), 64'd0);
        chk("rst_strobes", 64'({rs_en, lsb_en, ren_en}), 64'd0);
        chk("rst_tag", 64'(iss_tag), 64'd0);
        chk("rst_pc", 64'(iss_pc), 64'd0);
        rst_in = 1'b1;
        tick();
        chk("rst_ready", 64'(id_ready), 64'd1);

        // ALU addi rd=5: one cycle capture-to-issue latency, tag 0, rename rd.
        present(2'b00, 6'h13, 5'd5, 32'h0000_1000, t);
        chk("s1_acc", 64'(t), 64'd1);
        chk("s1_lat", 64'(rs_en), 64'd0);
        tick();
        chk("s1_rs_en", 64'(rs_en), 64'd1);
        chk("s1_rob_en", 64'(rob_en), 64'd1);
        chk("s1_tag", 64'(iss_tag), 64'd0);
        chk("s1_ren", 64'(ren_en), 64'd1);
        chk("s1_ren_rd", 64'(ren_rd), 64'd5);

        // 16 back-to-back loads exhaust the LSB; a free at full credit is ignored.
        do_reset();
        lsb_free = 1'b1;
        tick();
        lsb_free = 1'b0;
        lsb_cnt = 0;
        rob_commit = 1'b1;
        for (int i = 0; i < 17; i++) begin
            present(2'b01, 6'h03, 5'(i + 1), 32'h2000 + 32'(i * 4), t);
            chk("s2_acc", 64'(t), 64'd1);
        end
        rob_commit = 1'b0;
        tick();
        chk("s2_cnt", 64'(lsb_cnt), 64'd16);
        chk("s2_span", 64'(last_cyc - first_cyc), 64'd15);
        chk("s2_hold", 64'(lsb_en), 64'd0);
        chk("s2_ready", 64'(id_ready), 64'd0);
        tick();
        chk("s2_hold2", 64'(lsb_en), 64'd0);
        lsb_free = 1'b1;
        #1;
        chk("s2_ready_free", 64'(id_ready), 64'd1);
        tick();
        lsb_free = 1'b0;
        chk("s2_wrap_en", 64'(lsb_en), 64'd1);
        chk("s2_wrap_tag", 64'(iss_tag), 64'd0);

        // Store never renames; branch with rd=x0 does not rename; stall drops id_en.
        do_reset();
        present(2'b10, 6'h23, 5'h1F, 32'h3000, t);
        chk("s3_acc_st", 64'(t), 64'd1);
        present(2'b11, 6'h63, 5'd0, 32'h3004, t);
        chk("s3_acc_br", 64'(t), 64'd1);
        chk("s3_st_lsb", 64'(lsb_en), 64'd1);
        chk("s3_st_ren", 64'(ren_en), 64'd0);
        tick();
        chk("s3_br_rs", 64'(rs_en), 64'd1);
        chk("s3_br_ren", 64'(ren_en), 64'd0);
        rdy_in = 1'b0;
        present(2'b00, 6'h33, 5'd9, 32'h3008, t);
        tick();
        rdy_in = 1'b1;
        tick();
        chk("s3_rdy_drop", 64'(rs_en), 64'd0);
        tick();
        chk("s3_rdy_drop2", 64'(rs_en), 64'd0);

        // RS credit at zero: a same-cycle rs_free lets the held ALU op go, credit stays 0.
        do_reset();
        rob_commit = 1'b1;
        for (int i = 0; i < 17; i++) begin
            present(2'b00, 6'h13, 5'(i + 1), 32'h4000 + 32'(i * 4), t);
            chk("s4_acc", 64'(t), 64'd1);
        end
        rob_commit = 1'b0;
        tick();
        tick();
        chk("s4_ready", 64'(id_ready), 64'd0);
        chk("s4_hold", 64'(rs_en), 64'd0);
        rs_free = 1'b1;
        #1;
        chk("s4_ready_free", 64'(id_ready), 64'd1);
        tick();
        rs_free = 1'b0;
        chk("s4_bypass", 64'(rs_en), 64'd1);
        present(2'b00, 6'h13, 5'd20, 32'h4100, t);
        chk("s4_acc2", 64'(t), 64'd1);
        tick();
        chk("s4_cr_zero", 64'(rs_en), 64'd0);
        chk("s4_ready0", 64'(id_ready), 64'd0);
        rs_free = 1'b1;
        tick();
        rs_free = 1'b0;
        chk("s4_release", 64'(rs_en), 64'd1);

        // Clear after 5 dispatches: held op dropped, tag realigned, LSB keeps 3.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            present(2'b00, 6'h13, 5'(i + 1), 32'h5000 + 32'(i * 4), t);
            chk("s5_acc", 64'(t), 64'd1);
        end
        present(2'b00, 6'h13, 5'd6, 32'h5100, t);
        clear    = 1'b1;
        rob_head = 4'd7;
        lsb_kept = 5'd3;
        id_en    = 1'b1;
        id_pc    = 32'h5104;
        tick();
        clear = 1'b0;
        id_en = 1'b0;
        exp_q.delete();
        exp_tag = 7;
        chk("s5_no_strobe", 64'({rs_en, lsb_en, rob_en}), 64'd0);
        chk("s5_ready", 64'(id_ready), 64'd1);
        tick();
        chk("s5_no_strobe2", 64'({rs_en, lsb_en, rob_en}), 64'd0);
        lsb_cnt = 0;
        present(2'b01, 6'h03, 5'd1, 32'h5200, t);
        chk("s5_acc_ld", 64'(t), 64'd1);
        tick();
        chk("s5_first_lsb", 64'(lsb_en), 64'd1);
        chk("s5_tag", 64'(iss_tag), 64'd7);
        for (int i = 1; i < 14; i++) begin
            present(2'b01, 6'h03, 5'(i + 1), 32'h5200 + 32'(i * 4), t);
            chk("s5_acc_lds", 64'(t), 64'd1);
        end
        tick();
        tick();
        chk("s5_lsb_cnt", 64'(lsb_cnt), 64'd13);
        chk("s5_ready_hold", 64'(id_ready), 64'd0);

        // Asynchronous reset while an issue strobe is up and the buffer is full.
        lsb_free = 1'b1;
        present(2'b01, 6'h03, 5'd2, 32'h6000, t);
        lsb_free = 1'b0;
        chk("s6_acc", 64'(t), 64'd1);
        chk("s6_pre", 64'(lsb_en), 64'd1);
        #1;
        rst_in = 1'b0;
        #1;
        chk("s6_rst_lsb", 64'(lsb_en), 64'd0);
        chk("s6_rst_rob", 64'(rob_en), 64'd0);
        chk("s6_rst_tag", 64'(iss_tag), 64'd0);
        chk("s6_rst_pc", 64'(iss_pc), 64'd0);
        chk("s6_rst_ren_rd", 64'(ren_rd), 64'd0);
        tick();
        exp_q.delete();
        exp_tag = 0;
        rst_in = 1'b1;
        tick();
        present(2'b00, 6'h13, 5'd7, 32'h6100, t);
        chk("s6_acc2", 64'(t), 64'd1);
        tick();
        chk("s6_rs_en", 64'(rs_en), 64'd1);
        chk("s6_tag", 64'(iss_tag), 64'd0);
        tick();
        chk("q_drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
